// File: rtl/series_to_parrel_fsk.sv
// series_to_parrel_fsk: FSK receive-side serial-to-parallel converter.
// Oversampled demodulated bits are resolved by a 3-sample mid-bit majority
// vote and reassembled LSB first into WIDTH-bit words, each announced with
// a one-cycle data_valid strobe.
module series_to_parrel_fsk #(
  parameter int WIDTH = 16,
  parameter int OSR   = 16
) (
  input  logic             clk_256,
  input  logic             reset,
  input  logic             demod_bit,
  input  logic             frame_start,
  output logic [WIDTH-1:0] sig_to_dac,
  output logic             data_valid,
  output logic             noisy,
  output logic             busy
);

  localparam int SW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(OSR - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OSR / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OSR / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t           state, state_n;
  logic [SW-1:0]    s, s_n, s_cur;
  logic [BW-1:0]    b, b_n, b_cur;
  logic [WIDTH-1:0] shift, shift_n, shift_cur;
  logic             acc, acc_n, acc_cur;
  logic             v0, v0_n, v1, v1_n;
  logic [WIDTH-1:0] dout_n;
  logic             noisy_n, valid_n;
  logic             active, vote, unanimous;

  assign busy = (state == RECV);

  // Next-state logic: a frame_start restarts counting at sample 0 of bit 0
  // using this cycle's sample, so it naturally pre-empts a last-bit decision.
  always_comb begin
    state_n   = state;
    s_n       = s;
    b_n       = b;
    shift_n   = shift;
    acc_n     = acc;
    v0_n      = v0;
    v1_n      = v1;
    dout_n    = sig_to_dac;
    noisy_n   = noisy;
    valid_n   = 1'b0;
    active    = frame_start || (state == RECV);
    s_cur     = frame_start ? '0 : s;
    b_cur     = frame_start ? '0 : b;
    shift_cur = frame_start ? '0 : shift;
    acc_cur   = frame_start ? 1'b0 : acc;
    vote      = (v0 & v1) | (v0 & demod_bit) | (v1 & demod_bit);
    unanimous = (v0 == v1) && (v1 == demod_bit);

    if (active) begin
      state_n = RECV;
      shift_n = shift_cur;
      acc_n   = acc_cur;

      if (s_cur == S_V0) v0_n = demod_bit;
      if (s_cur == S_V1) v1_n = demod_bit;

      if (s_cur == S_V2) begin
        shift_n[b_cur] = vote;
        if (!unanimous) acc_n = 1'b1;
        if (b_cur == B_LAST) begin
          dout_n  = shift_n;
          noisy_n = acc_n;
          valid_n = 1'b1;
          shift_n = '0;
          acc_n   = 1'b0;
        end
      end

      if (s_cur == S_LAST) begin
        s_n = '0;
        b_n = (b_cur == B_LAST) ? '0 : b_cur + BW'(1);
      end else begin
        s_n = s_cur + SW'(1);
        b_n = b_cur;
      end
    end
  end

  // State and output registers with synchronous reset that discards any partial word.
  always_ff @(posedge clk_256) begin
    if (reset) begin
      state      <= IDLE;
      s          <= '0;
      b          <= '0;
      shift      <= '0;
      acc        <= 1'b0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      sig_to_dac <= '0;
      noisy      <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      s          <= s_n;
      b          <= b_n;
      shift      <= shift_n;
      acc        <= acc_n;
      v0         <= v0_n;
      v1         <= v1_n;
      sig_to_dac <= dout_n;
      noisy      <= noisy_n;
      data_valid <= valid_n;
    end
  end

endmodule

// File: doc/series_to_parrel_fsk.md
Name: series_to_parrel_fsk

Overview:
Receive-side counterpart of the FSK parallel-to-serial transmitter.
- Takes the demodulated serial bit stream at OSR samples per bit on the fast clock.
- Recovers bit values by 3-sample majority vote at mid-bit.
- Reassembles WIDTH-bit words, LSB first, matching the transmitter's bit order (bit 0 first, then bits 1..WIDTH-1, with frames back-to-back).
- Presents each word with a one-cycle valid strobe to the downstream DAC/sink stage.

Parameters:
WIDTH, 16, bits per frame/word.
OSR, 16, clk_256 cycles per serial bit (must be >= 4).

Ports:
clk_256  in  1  single clock; samples demod_bit every cycle.
reset  in  1  synchronous, active-high reset.
demod_bit  in  1  demodulated serial data (FSK detector output), synchronous to clk_256.
frame_start  in  1  one-cycle pulse; marks the cycle that is sample 0 of bit 0 of a frame (receive-side image of trans_enable).
sig_to_dac  out  WIDTH  last fully received word; held between updates.
data_valid  out  1  one-cycle pulse; sig_to_dac updated this cycle.
noisy  out  1  qualifies sig_to_dac; 1 if any vote in that frame was non-unanimous.
busy  out  1  1 while in RECV.

Behaviour:
- Reset (synchronous, at clk_256 rising edge with reset=1):
  - State = IDLE; sample counter s = 0; bit index b = 0; shift register = 0; vote accumulators cleared.
  - Outputs: sig_to_dac = 0, data_valid = 0, noisy = 0, busy = 0.
  - Reset overrides frame_start and any frame in progress. The partial word is discarded and no valid is issued.
- States:
  - IDLE: ignore demod_bit; on frame_start go to RECV with s = 0, b = 0. The frame_start cycle's demod_bit is sample 0 of bit 0.
  - RECV: advance s each cycle. On s = OSR-1, s wraps to 0 and b increments. On b = WIDTH-1 and s = OSR-1, b wraps to 0 and the next frame begins immediately, with no re-sync needed for continuous streaming. RECV is left only by reset.
- Voting:
  - Capture demod_bit at s = OSR/2-1, OSR/2 and OSR/2+1.
  - At s = OSR/2+1 the bit value is the majority of the three samples; it is written to shift position b (LSB first).
  - If the three samples are not all equal, set the per-frame noisy accumulator.
- Word output:
  - The cycle after the decision for b = WIDTH-1, sig_to_dac takes the complete word, noisy takes the accumulator, and data_valid = 1 for exactly one cycle.
  - The accumulator and shift register then clear for the next frame.
- Latency: frame_start at cycle T gives data_valid at T + (WIDTH-1)*OSR + OSR/2 + 2. With defaults this is T+250. Subsequent words follow every WIDTH*OSR = 256 cycles.
- frame_start while in RECV (re-alignment):
  - Abort the current frame: no data_valid for it; shift register and accumulator cleared.
  - Restart at s = 0, b = 0 using that cycle's sample.
  - This applies even when frame_start coincides with the last-bit decision cycle; frame_start wins.
  - A data_valid already scheduled for the following cycle (from a decision in the previous cycle) still fires.
- busy = 1 from the cycle after frame_start is accepted until reset.
- sig_to_dac and noisy change only on data_valid or reset.

Test Plan:
1. Reset held 3 cycles, then frame_start at T with the stream for 0xA5C3 (LSB first, 16 samples/bit, clean) -> data_valid=1 only at T+250; sig_to_dac=0xA5C3, noisy=0; busy=1 from T+1.
2. Three back-to-back frames 0x0001, 0x8000, 0xFFFF after a single frame_start at T -> valid at T+250, T+506, T+762 with those values; sig_to_dac stable between pulses.
3. Frame 0x1234 with demod_bit inverted only at s=8 of bit 3 -> sig_to_dac=0x1234, noisy=1. The next clean frame 0x1234 -> noisy=0. Inverting s=7 and s=8 of bit 0 instead -> 0x1235, noisy=1.
4. frame_start at T, second frame_start at T+100, then stream 0x5A5A aligned to T+100 -> no valid near T+250; valid at T+350 with 0x5A5A.
5. Reset asserted at T+200 during a frame -> all outputs 0 at T+201, no valid; stream without frame_start -> stays IDLE, data_valid never asserts.
6. frame_start exactly at T+249 (last decision cycle) -> no valid at T+250. Separately, frame_start at T+250 -> valid still fires at T+250, and the next valid arrives at T+500.
